serial_alu: RTL and testbench
=============================

SERIAL_ALU -- requirements
Module: serial_alu

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits.
REQ-002 Parameter DIGIT, default 4: bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT, and elaboration SHALL fail otherwise.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 op  input  alu_op_t  operation (ALU_ADD, SUB, LUI, SLL, SRL, SRA, AUIPC, SLT, SLTU, XOR, OR, AND); sampled on accept.
REQ-006 alu_input1, alu_input2  input  WIDTH each  operands; sampled on accept.
REQ-007 in_valid  input  1  request present.
REQ-008 in_ready  output  1  block can accept a request.
REQ-009 out_valid  output  1  result holds a completed result.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 result  output  WIDTH  completed result.

Function
REQ-012 Accept SHALL occur on a rising edge where in_valid and in_ready are both 1; op and both operands SHALL be registered at that edge.
REQ-013 FSM states: IDLE, RUN, DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-014 Transitions: IDLE->RUN on accept; RUN->DONE when the cycle count is exhausted; DONE->IDLE on an edge with out_ready=1; all other cases hold state.
REQ-015 Let N = WIDTH/DIGIT; ADD, SUB, AUIPC, XOR, OR, AND, LUI SHALL process one DIGIT-bit digit per RUN cycle, LSB digit first, with carry/borrow held in a flop between digits, taking exactly N RUN cycles.
REQ-016 SUB SHALL compute alu_input1 + ~alu_input2 + 1, modulo 2^WIDTH; ADD and AUIPC SHALL compute the sum modulo 2^WIDTH; LUI SHALL return alu_input2.
REQ-017 SLT and SLTU SHALL run the serial subtraction for N cycles and return 1 (zero-extended) if input1<input2, signed or unsigned respectively, else 0.
REQ-018 Shift amount SHALL be alu_input2 & (2*WIDTH-1).
REQ-019 SLL, SRL and SRA SHALL shift by up to DIGIT positions per RUN cycle, taking max(1, ceil(amount/DIGIT)) RUN cycles.
REQ-020 Amounts >= WIDTH SHALL yield 0 for SLL/SRL and WIDTH copies of alu_input1 MSB for SRA.
REQ-021 An op value outside the defined set SHALL complete after 1 RUN cycle with result 0.
REQ-022 result SHALL remain stable throughout DONE, even if operands or op change.
REQ-023 in_valid while not in IDLE SHALL be ignored: no accept, and no effect on state.
REQ-024 Latency: out_valid SHALL rise exactly C+1 edges after the accept edge, where C is the RUN cycle count; with out_ready held at 1, the next accept can occur 1 edge after the DONE->IDLE transition (throughput C+2 cycles per op).

Reset
REQ-025 While reset=1, and immediately on its assertion: state=IDLE, in_ready=1, out_valid=0, result=0, carry and count registers=0; flags (if present)=0.
REQ-026 Reset asserted mid-RUN or in DONE SHALL discard the operation; no out_valid pulse SHALL follow.

Configuration
REQ-027 Macro SERIAL_ALU_FLAGS_EN defined: add outputs flag_zero, flag_carry and flag_overflow (1 bit each), valid with out_valid and stable in DONE.
REQ-028 flag_zero = (result==0).
REQ-029 flag_carry = carry-out for ADD/AUIPC and the inverted borrow for SUB/SLT/SLTU; 0 otherwise.
REQ-030 flag_overflow = signed overflow for ADD/AUIPC/SUB; 0 otherwise.
REQ-031 Macro SERIAL_ALU_FLAGS_EN undefined: these ports and their logic SHALL be absent; all other behaviour is identical.

Verification (WIDTH=16, DIGIT=4)
REQ-032 ADD 0x1234+0x0FFF, out_ready=1 -> result 0x2233, out_valid exactly 5 edges after accept.
REQ-033 SUB 0x0000-0x0001 -> 0xFFFF; with flags: carry=0, overflow=0, zero=0. SUB 0x8000-0x0001 -> 0x7FFF, overflow=1.
REQ-034 SLT 0xFFFF vs 0x0001 -> 1; SLTU with the same operands -> 0; each shows 4 RUN cycles.
REQ-035 SRA 0x8000 by 3 -> 0xF000 after 1 RUN cycle; SLL 0x00FF by 9 -> 0xFE00 after 3 RUN cycles; SLL by 20 -> 0x0000; SRA 0x8000 by 20 -> 0xFFFF.
REQ-036 out_ready=0 for 6 cycles in DONE -> result stable and in_ready=0; in_valid pulses are ignored; the request is accepted after out_ready rises.
REQ-037 Reset asserted on the 2nd RUN cycle of an ADD -> outputs immediately at reset values; no out_valid; the next ADD completes normally.

Source files
------------

// File: rtl/serial_alu.sv
// Digit-serial ALU: arithmetic/logic ops walk one DIGIT-bit digit per cycle, shifts move up to DIGIT places per cycle.
// Define SERIAL_ALU_FLAGS_EN to add the flag_zero/flag_carry/flag_overflow outputs.
module serial_alu #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] alu_input1,
  input  logic [WIDTH-1:0] alu_input2,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
`ifdef SERIAL_ALU_FLAGS_EN
  ,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_overflow
`endif
);

  localparam int NDIG = WIDTH / DIGIT;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_LUI   = 4'd2;
  localparam logic [3:0] OP_SLL   = 4'd3;
  localparam logic [3:0] OP_SRL   = 4'd4;
  localparam logic [3:0] OP_SRA   = 4'd5;
  localparam logic [3:0] OP_AUIPC = 4'd6;
  localparam logic [3:0] OP_SLT   = 4'd7;
  localparam logic [3:0] OP_SLTU  = 4'd8;
  localparam logic [3:0] OP_XOR   = 4'd9;
  localparam logic [3:0] OP_OR    = 4'd10;
  localparam logic [3:0] OP_AND   = 4'd11;

  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_alu: WIDTH must be an integer multiple of DIGIT");
  end

  function automatic logic is_shift_op(input logic [3:0] o);
    return (o == OP_SLL) || (o == OP_SRL) || (o == OP_SRA);
  endfunction

  function automatic logic is_sub_op(input logic [3:0] o);
    return (o == OP_SUB) || (o == OP_SLT) || (o == OP_SLTU);
  endfunction

  function automatic logic is_digit_op(input logic [3:0] o);
    return (o == OP_ADD) || (o == OP_SUB) || (o == OP_AUIPC) || (o == OP_LUI) ||
           (o == OP_XOR) || (o == OP_OR) || (o == OP_AND) || (o == OP_SLT) || (o == OP_SLTU);
  endfunction

  logic [1:0]       state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [DIGIT-1:0] a_dig_s, b_dig_s, dig_s;
  logic [DIGIT:0]   sum_s;
  logic [WIDTH-1:0] digit_acc_s, shifted_s, step_s, final_s;
  logic             ovf_s, lt_signed_s, lt_unsigned_s, last_s;

  assign a_dig_s = a_q[DIGIT-1:0];
  assign b_dig_s = is_sub_op(op_q) ? ~b_q[DIGIT-1:0] : b_q[DIGIT-1:0];
  assign sum_s   = {1'b0, a_dig_s} + {1'b0, b_dig_s} + {{DIGIT{1'b0}}, carry_q};

  // Only meaningful on the top digit, where a_dig_s/b_dig_s hold the operand sign bits.
  assign ovf_s         = (a_dig_s[DIGIT-1] == b_dig_s[DIGIT-1]) && (sum_s[DIGIT-1] != a_dig_s[DIGIT-1]);
  assign lt_signed_s   = sum_s[DIGIT-1] ^ ovf_s;
  assign lt_unsigned_s = ~sum_s[DIGIT];

  assign digit_acc_s = (acc_q >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));
  assign step_s      = (cnt_q > WIDTH'(DIGIT)) ? WIDTH'(DIGIT) : cnt_q;

  // Per-digit operation result.
  always_comb begin
    dig_s = sum_s[DIGIT-1:0];
    case (op_q)
      OP_XOR:  dig_s = a_dig_s ^ b_dig_s;
      OP_OR:   dig_s = a_dig_s | b_dig_s;
      OP_AND:  dig_s = a_dig_s & b_dig_s;
      OP_LUI:  dig_s = b_dig_s;
      default: dig_s = sum_s[DIGIT-1:0];
    endcase
  end

  // Partial shift of the accumulator by this cycle's step.
  always_comb begin
    shifted_s = acc_q;
    case (op_q)
      OP_SLL:  shifted_s = acc_q << step_s;
      OP_SRL:  shifted_s = acc_q >> step_s;
      OP_SRA:  shifted_s = $signed(acc_q) >>> step_s;
      default: shifted_s = acc_q;
    endcase
  end

  // Last-RUN-cycle detection and the value latched into result.
  always_comb begin
    last_s  = 1'b1;
    final_s = '0;
    if (is_shift_op(op_q)) begin
      last_s = (cnt_q <= WIDTH'(DIGIT));
    end else if (is_digit_op(op_q)) begin
      last_s = (cnt_q == '0);
    end else begin
      last_s = 1'b1;
    end
    case (op_q)
      OP_SLT:                  final_s = WIDTH'(lt_signed_s);
      OP_SLTU:                 final_s = WIDTH'(lt_unsigned_s);
      OP_SLL, OP_SRL, OP_SRA:  final_s = shifted_s;
      OP_ADD, OP_SUB, OP_AUIPC,
      OP_XOR, OP_OR, OP_AND,
      OP_LUI:                  final_s = digit_acc_s;
      default:                 final_s = '0;
    endcase
  end

  // Control FSM and datapath next state.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_RUN;
          op_d    = op;
          a_d     = alu_input1;
          b_d     = alu_input2;
          carry_d = is_sub_op(op);
          if (is_shift_op(op)) begin
            acc_d = alu_input1;
            cnt_d = alu_input2 & WIDTH'(2 * WIDTH - 1);
          end else begin
            acc_d = '0;
            cnt_d = WIDTH'(NDIG - 1);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (is_shift_op(op_q)) begin
          acc_d = shifted_s;
          cnt_d = cnt_q - step_s;
        end else begin
          acc_d   = digit_acc_s;
          a_d     = a_q >> DIGIT;
          b_d     = b_q >> DIGIT;
          carry_d = sum_s[DIGIT];
          cnt_d   = cnt_q - WIDTH'(1);
        end
        if (last_s) begin
          state_d  = ST_DONE;
          result_d = final_s;
          carry_d  = 1'b0;
          cnt_d    = '0;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= 4'd0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;

`ifdef SERIAL_ALU_FLAGS_EN
  logic fz_q, fc_q, fo_q;

  // Flags are captured together with result and held through DONE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fz_q <= 1'b0;
      fc_q <= 1'b0;
      fo_q <= 1'b0;
    end else if ((state_q == ST_RUN) && last_s) begin
      fz_q <= (final_s == '0);
      fc_q <= ((op_q == OP_ADD) || (op_q == OP_AUIPC) || is_sub_op(op_q)) ? sum_s[DIGIT] : 1'b0;
      fo_q <= ((op_q == OP_ADD) || (op_q == OP_AUIPC) || (op_q == OP_SUB)) ? ovf_s : 1'b0;
    end else begin
      fz_q <= fz_q;
      fc_q <= fc_q;
      fo_q <= fo_q;
    end
  end

  assign flag_zero     = fz_q;
  assign flag_carry    = fc_q;
  assign flag_overflow = fo_q;
`endif

endmodule

// File: tb/tb_serial_alu.sv
// Scoreboard bench for serial_alu (WIDTH=16, DIGIT=4): driver pushes model results, monitor pops on out_valid.
module tb_serial_alu;
  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, LUI = 4'd2, SLL = 4'd3, SRL = 4'd4, SRA = 4'd5,
                         AUIPC = 4'd6, SLT = 4'd7, SLTU = 4'd8, XOR = 4'd9, OR = 4'd10, AND = 4'd11;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  op = 4'd0;
  logic [15:0] alu_input1 = 16'd0, alu_input2 = 16'd0;
  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid;
  logic [15:0] result;
`ifdef SERIAL_ALU_FLAGS_EN
  logic flag_zero, flag_carry, flag_overflow;
`endif

  serial_alu #(.WIDTH(16), .DIGIT(4)) dut (
    .clock(clock), .reset(reset), .op(op), .alu_input1(alu_input1), .alu_input2(alu_input2),
    .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .result(result)
`ifdef SERIAL_ALU_FLAGS_EN
    , .flag_zero(flag_zero), .flag_carry(flag_carry), .flag_overflow(flag_overflow)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] r;
    int          cyc;
    int          acc;
    logic        c;
    logic        v;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   edge_cnt = 0;
  bit   rand_rdy = 1'b0;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic on whole operands; cyc is the number of RUN cycles.
  function automatic exp_t model(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    logic [16:0] s;
    int amt;
    amt = int'(b & 16'd31);
    e.r = 16'd0; e.cyc = 4; e.acc = 0; e.c = 1'b0; e.v = 1'b0;
    case (o)
      ADD, AUIPC: begin
        s = {1'b0, a} + {1'b0, b};
        e.r = s[15:0]; e.c = s[16];
        e.v = (a[15] == b[15]) && (e.r[15] != a[15]);
      end
      SUB: begin
        s = {1'b0, a} + {1'b0, ~b} + 17'd1;
        e.r = s[15:0]; e.c = s[16];
        e.v = (a[15] != b[15]) && (e.r[15] != a[15]);
      end
      SLT:  begin e.r = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0; e.c = (a >= b); end
      SLTU: begin e.r = (a < b) ? 16'd1 : 16'd0; e.c = (a >= b); end
      XOR:  e.r = a ^ b;
      OR:   e.r = a | b;
      AND:  e.r = a & b;
      LUI:  e.r = b;
      SLL, SRL, SRA: begin
        e.cyc = (amt == 0) ? 1 : (amt + 3) / 4;
        if (o == SLL)      e.r = (amt >= 16) ? 16'd0 : (a << amt);
        else if (o == SRL) e.r = (amt >= 16) ? 16'd0 : (a >> amt);
        else               e.r = (amt >= 16) ? {16{a[15]}} : 16'($signed(a) >>> amt);
      end
      default: e.cyc = 1;
    endcase
    return e;
  endfunction

  // Called on a falling edge; holds the request until accepted, then scrambles the inputs.
  task automatic issue(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int w;
    op = o; alu_input1 = a; alu_input2 = b; in_valid = 1'b1; w = 0;
    while (!in_ready && w < 200) begin
      @(negedge clock);
      w++;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
    if (!in_ready) begin
      chk("accept_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
      return;
    end
    e = model(o, a, b);
    e.acc = edge_cnt + 1;
    sb.push_back(e);
    @(negedge clock);
    in_valid = 1'b0;
    op = 4'($urandom); alu_input1 = 16'($urandom); alu_input2 = 16'($urandom);
  endtask

  task automatic drain();
    int w;
    out_ready = 1'b1;
    w = 0;
    while (sb.size() != 0 && w < 500) begin
      @(negedge clock);
      w++;
    end
    chk("drain_empty", sb.size(), 32'd0);
    @(negedge clock);
  endtask

  // Monitor: first DONE cycle pops the scoreboard; later DONE cycles must hold result.
  bit          seen = 1'b0;
  logic [15:0] held;
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      seen = 1'b0;
    end else if (out_valid && !seen) begin
      seen = 1'b1;
      held = result;
      if (sb.size() == 0) begin
        chk("spurious_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("result", {16'd0, result}, {16'd0, e.r});
        // out_valid is seen after edge acc+C, i.e. C+1 edges counting the accept edge.
        chk("latency", edge_cnt - e.acc, e.cyc);
`ifdef SERIAL_ALU_FLAGS_EN
        chk("flag_zero", {31'd0, flag_zero}, {31'd0, (e.r == 16'd0)});
        chk("flag_carry", {31'd0, flag_carry}, {31'd0, e.c});
        chk("flag_overflow", {31'd0, flag_overflow}, {31'd0, e.v});
`endif
      end
    end else if (out_valid && seen) begin
      chk("hold_result", {16'd0, result}, {16'd0, held});
      chk("in_ready_in_done", {31'd0, in_ready}, 32'd0);
    end else begin
      seen = 1'b0;
    end
  end

  initial begin
    logic [3:0]  o;
    logic [15:0] a, b;
    repeat (3) @(negedge clock);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", {16'd0, result}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    issue(ADD, 16'h1234, 16'h0FFF);
    issue(SUB, 16'h0000, 16'h0001);
    issue(SUB, 16'h8000, 16'h0001);
    issue(SLT, 16'hFFFF, 16'h0001);
    issue(SLTU, 16'hFFFF, 16'h0001);
    issue(SRA, 16'h8000, 16'd3);
    issue(SLL, 16'h00FF, 16'd9);
    issue(SLL, 16'h00FF, 16'd20);
    issue(SRA, 16'h8000, 16'd20);
    issue(SRL, 16'hF00F, 16'd0);
    issue(4'd13, 16'h1234, 16'h5678);
    drain();

    // Consumer stall: result must hold and in_valid pulses must be ignored.
    out_ready = 1'b0;
    issue(XOR, 16'hA5A5, 16'h0FF0);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clock);
    chk("stall_reached_done", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'($urandom); op = 4'($urandom);
      alu_input1 = 16'($urandom); alu_input2 = 16'($urandom);
      @(negedge clock);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    issue(OR, 16'h1200, 16'h0034);
    drain();

    // Reset during the second RUN cycle of an ADD discards it.
    issue(ADD, 16'h1111, 16'h2222);
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("midrun_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrun_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrun_rst_result", {16'd0, result}, 32'd0);
    void'(sb.pop_back());
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (8) @(negedge clock);
    issue(ADD, 16'h0F0F, 16'h0101);
    drain();

    rand_rdy = 1'b1;
    for (int i = 0; i < 150; i++) begin
      o = 4'($urandom_range(0, 15));
      a = 16'($urandom);
      b = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 40)) : 16'($urandom);
      if (i % 5 == 0) a = {$urandom_range(0, 1) == 1, 15'h0000};
      issue(o, a, b);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
    rand_rdy = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
